interp2_sched: RTL
==================

# interp2_sched

Sequencer for the two-tap multiply-add datapath (`mult_add_2`) in the horizontal linear-interpolation scaler. It accepts one line of input pixels over a valid/ready handshake and drives the datapath on every cycle:
- FIR-mode shifting of the pixel pair;
- complementary weights from a fixed-point phase accumulator;
- bypass opcodes for integer phases and the right-edge clamp.

It also tracks the datapath pipeline, so a valid/last strobe is aligned with `result_data_o`.

## Interface
Parameters:
- `COEFF_W`, 8: weight width; equals `INPUT_DATA_B_W` of the datapath. Full scale is 2^COEFF_W.
- `FRAC_W`, 12: fractional bits of the step and the phase accumulator; must be ≥ COEFF_W.
- `INT_W`, 4: integer bits of the step (step < 16.0).
- `CNT_W`, 12: width of the line-length counters.
- `POST_REGS`, 0: the datapath's `POST_REGS`; sets result latency.

Ports:
- `CLK_i`  in  1  clock.
- `RST_i`  in  1  reset; one clock, synchronous, active-high.
- `start_i`  in  1  line-start pulse; ignored while `busy_o`.
- `step_i`  in  INT_W+FRAC_W  input/output pixel ratio; latched on start.
- `in_len_i`  in  CNT_W  input pixels in the line, ≥2; latched on start.
- `out_len_i`  in  CNT_W  output pixels to generate, ≥1; latched on start.
- `in_valid_i`  in  1  upstream pixel valid; the pixel itself goes straight to datapath `data_a0_i`.
- `in_ready_o`  out  1  pixel accepted when `in_valid_i & in_ready_o`.
- `inopcode_o`  out  2  to datapath `inopcode_i`: 00 nop, 10 fir_mode.
- `calcopcode_o`  out  2  to datapath `calcopcode_i`: 00 normal, 01 bypass_a0, 10 bypass_a1.
- `coeff_b0_o`  out  COEFF_W  to `data_b0_i`; weight of the newer pixel (a0).
- `coeff_b1_o`  out  COEFF_W  to `data_b1_i`; weight of the older pixel (a1).
- `busy_o`  out  1  line in progress (any state other than IDLE).
- `res_valid_o`  out  1  `result_data_o` holds an output pixel this cycle.
- `res_last_o`  out  1  that output pixel is the last of the line.

## Operation
- **Registered state:**
  - FSM state;
  - phase fraction `frac` (FRAC_W bits);
  - `skip`: inputs still to consume before the next output, INT_W+1 bits;
  - `in_left` and `out_left` counters;
  - latched step;
  - `clamp` flag.
- `inopcode_o`, `calcopcode_o` and the coefficients are combinational from state and `in_valid_i`. The datapath registers them.
- **Consume:** an accepted pixel drives `inopcode_o=10`, so a1 takes the old a0 and a0 takes the new pixel, and `in_left` decrements. When no pixel is accepted, `inopcode_o=00`.
- **IDLE:**
  - outputs are 0;
  - on `start_i`: latch step and lengths, set `in_left=in_len_i`, `out_left=out_len_i`, `frac=0`, `skip=0`, `clamp=0`, then go to PRIME.
- **PRIME:**
  - `in_ready_o=1`;
  - accept 2 pixels with no output issued;
  - then go to RUN, with a1=P0 and a0=P1.
- **RUN:**
  - `in_ready_o = (skip!=0) & !clamp`.
  - If `skip!=0` and `in_left==0`, set `clamp` (combinationally effective this cycle).
  - An output is issued when any of these holds:
    - `skip==0`;
    - `skip==1` and a pixel is accepted;
    - `clamp`.
  - A pending skip is decremented by an accepted pixel, or dropped when `clamp` is set.
  - On issue:
    - `next = frac + step`;
    - `skip = next >> FRAC_W`;
    - `frac = next[FRAC_W-1:0]`;
    - `out_left--`.
  - A `skip>1` cycle with an accepted pixel consumes only.
- **Issue coefficients:**
  - Let `f = frac[FRAC_W-1 -: COEFF_W]`.
  - `clamp`: `calcopcode_o=01` (newest pixel), coefficients 0.
  - Else `f==0`: `calcopcode_o=10` (older pixel), coefficients 0.
  - Else: `calcopcode_o=00`, `coeff_b0_o=f`, `coeff_b1_o=2^COEFF_W - f`. The two weights sum to full scale with no overflow.
- **Non-issue cycles:** `calcopcode_o=00`, coefficients 0.
- **End of line:** the issue that brings `out_left` to 0 moves the FSM to IDLE. That issue is tagged last.
- **Stall:** `in_valid_i` low while `skip>0` and not clamped means no consume, no issue, and all outputs 0.
- `step=0` is legal: every output repeats P0 via bypass_a1.

## Timing
- Result latency is L = 3+POST_REGS cycles. A 2-flag shift register (valid, last) of depth L takes `(issue, issue & out_left==1)`.
- `res_valid_o` and `res_last_o` assert exactly L cycles after the issue cycle.
- Maximum throughput is one output per clock.
- `in_ready_o` is never asserted in IDLE.
- Values on `RST_i`: all outputs 0, FSM in IDLE, shift register cleared.
- Reset mid-line:
  - the line is abandoned;
  - any in-flight `res_valid_o` pulses are dropped on the next clock;
  - no further `in_ready_o` until a new start.
- `start_i` asserted in the same cycle as the last issue is ignored (the FSM is still busy).

## Test plan
- **Unity ratio:** step=0x1000, in_len=4, out_len=4.
  - Calc ops in order: bypass_a1 (P0), fir+bypass_a1 (P1), fir+bypass_a1 (P2), then clamp bypass_a0 (P3).
  - `res_last_o` on the 4th result.
- **2x upscale:** step=0x0800, in_len=2, out_len=4.
  - Issues: bypass_a1; normal with b0=128/b1=128; clamp; clamp.
  - Exactly 2 pixels accepted.
- **2:1 downscale:** step=0x2000, in_len=8, out_len=4.
  - Pattern per output: consume-only cycle, then consume+issue.
  - 8 pixels accepted; all issues bypass_a1.
- **Stall:** drop `in_valid_i` for 5 cycles mid-RUN with skip=1.
  - `inopcode_o=00`, no issue and no `res_valid_o` gap-fill; the issue resumes in the cycle the pixel is accepted.
- **Latency:** with POST_REGS=1, `res_valid_o` trails each issue by exactly 4 cycles, and the count of `res_valid_o` pulses equals out_len.
- **Reset and start:**
  - `RST_i` for 1 cycle mid-line gives all outputs 0 and `busy_o=0` next cycle.
  - `start_i` pulsed while busy changes nothing.

Source files
------------

// File: rtl/interp2_sched_if.sv
`default_nettype none
// ============================================================================
// interp2_sched_if : line control and datapath-drive bundle for interp2_sched
// Revision 1.0
// ============================================================================
interface interp2_sched_if #(
  parameter int COEFF_W = 8,
  parameter int FRAC_W  = 12,
  parameter int INT_W   = 4,
  parameter int CNT_W   = 12
);
  logic                     start_i;
  logic [INT_W+FRAC_W-1:0]  step_i;
  logic [CNT_W-1:0]         in_len_i;
  logic [CNT_W-1:0]         out_len_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [1:0]               inopcode_o;
  logic [1:0]               calcopcode_o;
  logic [COEFF_W-1:0]       coeff_b0_o;
  logic [COEFF_W-1:0]       coeff_b1_o;
  logic                     busy_o;
  logic                     res_valid_o;
  logic                     res_last_o;

  modport master (
    output start_i, step_i, in_len_i, out_len_i, in_valid_i,
    input  in_ready_o, inopcode_o, calcopcode_o, coeff_b0_o, coeff_b1_o,
           busy_o, res_valid_o, res_last_o
  );

  modport slave (
    input  start_i, step_i, in_len_i, out_len_i, in_valid_i,
    output in_ready_o, inopcode_o, calcopcode_o, coeff_b0_o, coeff_b1_o,
           busy_o, res_valid_o, res_last_o
  );
endinterface
`default_nettype wire

// File: rtl/interp2_sched.sv
`default_nettype none
// ============================================================================
// interp2_sched : phase-accumulator sequencer for the mult_add_2 linear scaler
// Revision 1.0
// ============================================================================
module interp2_sched #(
  parameter int COEFF_W   = 8,
  parameter int FRAC_W    = 12,
  parameter int INT_W     = 4,
  parameter int CNT_W     = 12,
  parameter int POST_REGS = 0
) (
  input  logic            CLK_i,
  input  logic            RST_i,
  interp2_sched_if.slave  bus
);
  localparam int STEP_W = INT_W + FRAC_W;
  localparam int SKIP_W = INT_W + 1;
  localparam int SUM_W  = STEP_W + 1;
  localparam int LAT    = 3 + POST_REGS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state;
  logic [FRAC_W-1:0]   frac;
  logic [SKIP_W-1:0]   skip;
  logic [CNT_W-1:0]    in_left;
  logic [CNT_W-1:0]    out_left;
  logic [STEP_W-1:0]   step;
  logic                clamp;
  logic                primed;
  logic [LAT-1:0]      vld_sr;
  logic [LAT-1:0]      lst_sr;

  logic                skip_nz;
  logic                clamp_now;
  logic                ready;
  logic                accept;
  logic                issue;
  logic [SUM_W-1:0]    next_pos;
  logic [COEFF_W-1:0]  f;
  logic [1:0]          calcop;
  logic [COEFF_W-1:0]  b0;
  logic [COEFF_W-1:0]  b1;

  always_comb begin
    skip_nz   = (skip != '0);
    // Running out of input while a skip is pending pins the rest of the line to the last pixel.
    clamp_now = (state == RUN) && (clamp || (skip_nz && (in_left == '0)));
    ready     = 1'b0;
    case (state)
      PRIME:   ready = 1'b1;
      RUN:     ready = skip_nz && !clamp_now;
      default: ready = 1'b0;
    endcase
    ready    = ready && !RST_i;
    accept   = bus.in_valid_i && ready;
    issue    = (state == RUN) && !RST_i &&
               (!skip_nz || ((skip == SKIP_W'(1)) && accept) || clamp_now);
    next_pos = {{SKIP_W{1'b0}}, frac} + {1'b0, step};
    f        = frac[FRAC_W-1 -: COEFF_W];
    calcop   = 2'b00;
    b0       = '0;
    b1       = '0;
    if (issue) begin
      if (clamp_now) begin
        calcop = 2'b01;
      end else if (f == '0) begin
        calcop = 2'b10;
      end else begin
        b0 = f;
        // f is non-zero here, so the modular negate equals full scale minus f.
        b1 = COEFF_W'(0) - f;
      end
    end
  end

  assign bus.in_ready_o   = ready;
  assign bus.inopcode_o   = accept ? 2'b10 : 2'b00;
  assign bus.calcopcode_o = calcop;
  assign bus.coeff_b0_o   = b0;
  assign bus.coeff_b1_o   = b1;
  assign bus.busy_o       = (state != IDLE);
  assign bus.res_valid_o  = vld_sr[LAT-1];
  assign bus.res_last_o   = lst_sr[LAT-1];

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state    <= IDLE;
      frac     <= '0;
      skip     <= '0;
      in_left  <= '0;
      out_left <= '0;
      step     <= '0;
      clamp    <= 1'b0;
      primed   <= 1'b0;
      vld_sr   <= '0;
      lst_sr   <= '0;
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], issue};
      lst_sr <= {lst_sr[LAT-2:0], issue && (out_left == CNT_W'(1))};
      if (accept) begin
        in_left <= in_left - CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            step     <= bus.step_i;
            in_left  <= bus.in_len_i;
            out_left <= bus.out_len_i;
            frac     <= '0;
            skip     <= '0;
            clamp    <= 1'b0;
            primed   <= 1'b0;
            state    <= PRIME;
          end
        end
        PRIME: begin
          if (accept) begin
            primed <= 1'b1;
            if (primed) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (clamp_now) begin
            clamp <= 1'b1;
          end
          if (issue) begin
            skip     <= next_pos[SUM_W-1:FRAC_W];
            frac     <= next_pos[FRAC_W-1:0];
            out_left <= out_left - CNT_W'(1);
            if (out_left == CNT_W'(1)) begin
              state <= IDLE;
            end
          end else if (accept) begin
            skip <= skip - SKIP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
